nand4_exhaustive_tester: RTL
============================

# nand4_exhaustive_tester

On-chip exhaustive stimulus and check stage for the 4-input NAND built from 2-input NANDs. It sits directly upstream of the gate and drives its input vector `i[3:0]` through all 2^WIDTH combinations. It samples the gate output `y` after a programmable settle time and compares it against the expected `~&i`. At the end of a sweep it reports mismatch count, first failing vector and pass/fail.

## Interface
Parameters:
- `WIDTH`, 4, number of gate inputs; the sweep covers 2^WIDTH vectors.
- `SETTLE`, 1, cycles each vector is held stable before sampling. Must be ≥1; values <1 are an elaboration error.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  level; sampled only in IDLE; begins a sweep.
- `vec_o`  out  WIDTH  drives the gate input `i`.
- `y_i`  in  1  gate output `y`.
- `busy`  out  1  high from the first drive cycle through the last CHECK cycle.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  `err_cnt==0`; valid from `done` until the next accepted `start`.
- `err_cnt`  out  WIDTH+1  mismatch count, 0..2^WIDTH; no saturation needed.
- `first_fail_vec`  out  WIDTH  vector of the first mismatch in the sweep.
- `first_fail_valid`  out  1  set on the first mismatch; held until the next accepted `start`.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- Reset (`rst_n=0` at an edge) sets state=IDLE, `vec_o`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_fail_vec`=0, `first_fail_valid`=0, settle counter=0.
- IDLE with `start=1`: go to SETTLE. Clear `err_cnt`, `first_fail_valid`, `first_fail_vec` and `pass`. Set `vec_o`=0 and `busy`=1.
- SETTLE: hold `vec_o`. The settle counter counts SETTLE cycles, then the state moves to CHECK.
- CHECK: compare `y_i` with `~&vec_o`.
  - On mismatch, `err_cnt`+1.
  - If `first_fail_valid` is 0, capture `vec_o` into `first_fail_vec` and set `first_fail_valid`.
- Leaving CHECK:
  - If `vec_o` = all-ones, go to DONE.
  - Otherwise, increment `vec_o` (binary count, no wrap inside a sweep) and return to SETTLE.
- DONE (one cycle): `done`=1, `busy`=0, `pass`=(`err_cnt`==0), `vec_o` returns to 0. Next state is IDLE.
- `start` outside IDLE is ignored. This includes the DONE cycle and a `start` held high through a sweep. A `start` held high is accepted again in the IDLE cycle after DONE.
- Reset mid-sweep: the next edge applies the reset values. No `done` pulse is produced and partial results are discarded.
- Mismatch in the same CHECK cycle as the final vector is counted before DONE; `pass` reflects it.

## Timing
- Cycle 0: `start` sampled in IDLE. Vector k enters SETTLE at cycle 1 + k·(SETTLE+1).
- Vector k is sampled in CHECK at cycle (k+1)·(SETTLE+1).
- `done` is high at cycle 2^WIDTH·(SETTLE+1)+1. For defaults that is cycle 33; for SETTLE=3 it is cycle 65.
- `busy` is high in cycles 1..2^WIDTH·(SETTLE+1).
- All outputs are registered; there is no combinational path from `y_i` or `start` to any output.
- The gate path `vec_o`→`y_i` must settle within SETTLE cycles.

## Structure
- Shared package/header `nand_test_pkg` holds:
  - state encodings: IDLE=2'd0, SETTLE=2'd1, CHECK=2'd2, DONE=2'd3;
  - a `clog2`-style function used for the settle-counter width.
- Sub-module `settle_timer`: loadable down-counter with synchronous active-low reset. Inputs are `load` and `en`; output is `expired`. It is instantiated once.
- Top-level FSM, vector counter and result registers live in `nand4_exhaustive_tester`. The expected value is a one-line reduction, not a separate module.

## Test plan
- Correct 4-input NAND on `vec_o`→`y_i`, defaults, `start` pulsed at cycle 0 → `vec_o` walks 0..15, `done` at cycle 33, `pass`=1, `err_cnt`=0, `first_fail_valid`=0.
- `y_i` tied 1 → `err_cnt`=1, `first_fail_vec`=4'hF, `first_fail_valid`=1, `pass`=0.
- `y_i` tied 0 → `err_cnt`=15, `first_fail_vec`=4'h0, `pass`=0.
- `rst_n` low for one edge at cycle 10 → next cycle `busy`=0, `vec_o`=0, `err_cnt`=0, and no `done` pulse in the following 40 cycles.
- `start` held high for 80 cycles with the correct gate → `done` pulses at cycles 33 and 67 only; `busy` is low in cycles 33 and 34 (the DONE and IDLE cycles between sweeps).
- SETTLE=3 with the correct gate → each vector held 3 cycles before CHECK, `done` at cycle 65, `pass`=1.

Source files
------------

// File: rtl/nand_test_pkg.sv
// Shared definitions for the NAND exhaustive tester: FSM state encoding and a
// width helper for the settle counter.
package nand_test_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StCheck  = 2'd2,
        StDone   = 2'd3
    } state_e;

    // Ceiling log2; clog2(1) is 0, so callers clamp the width to at least 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < 64'(value)) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that measures how long a vector has been held before
// it is sampled. expired is high once the loaded count has run out.
module settle_timer
    import nand_test_pkg::*;
#(
    parameter int unsigned CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (CYCLES > 1) ? clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Loading CYCLES-1 makes expired rise in the CYCLES-th enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/nand4_exhaustive_tester.sv
// Exhaustive stimulus/check stage for a WIDTH-input NAND: walks every input
// vector, samples the gate after SETTLE cycles and reports sweep results.
module nand4_exhaustive_tester
    import nand_test_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int          SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] vec_o,
    input  logic             y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_cnt,
    output logic [WIDTH-1:0] first_fail_vec,
    output logic             first_fail_valid
);

    if (SETTLE < 1) begin : g_bad_settle
        $error("SETTLE must be at least 1");
    end

    localparam int unsigned SETTLE_CYC = (SETTLE < 1) ? 1 : SETTLE;
    localparam logic [WIDTH-1:0] VEC_ONE = WIDTH'(1);
    localparam logic [WIDTH:0]   ERR_ONE = (WIDTH + 1)'(1);

    state_e state;
    logic   expected;
    logic   mismatch;
    logic   last_vec;
    logic   timer_load;
    logic   timer_en;
    logic   timer_expired;

    assign expected = ~&vec_o;
    assign mismatch = y_i ^ expected;
    assign last_vec = &vec_o;

    // Reload on every entry into SETTLE: sweep start and each vector advance.
    assign timer_load = ((state == StIdle) && start) || ((state == StCheck) && !last_vec);
    assign timer_en   = (state == StSettle);

    settle_timer #(
        .CYCLES (SETTLE_CYC)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= StIdle;
            vec_o            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_cnt          <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        state            <= StSettle;
                        vec_o            <= '0;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        err_cnt          <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                StSettle: begin
                    if (timer_expired) begin
                        state <= StCheck;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + ERR_ONE;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec_o;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (last_vec) begin
                        // Final vector's own mismatch must count toward pass.
                        state <= StDone;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_cnt == '0) && !mismatch;
                        vec_o <= '0;
                    end else begin
                        state <= StSettle;
                        vec_o <= vec_o + VEC_ONE;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
